// File: rtl/crypto1_key_shifter_if.sv
// crypto1_key_shifter_if
//
// Signal bundle between a search core / attack aggregator and one key shifter.
//
// Signals:
//   LOAD        strobe from the search core that captures LOAD_STATE
//   LOAD_STATE  48-bit matched candidate LFSR state, x[k] = bit k
//   CLR         synchronous return to idle
//   KEY_CLK     serial bit clock from the aggregator (CLK-synchronous level)
//   KEY_DATA    serial key bit, MSB first
//   KEY_VALID   a rewound key is being presented
//   BUSY        rewinding or sending
//   SENT        all 48 bits have been transferred
//
// Modports:
//   master  controlling side (core + aggregator); drives strobes and KEY_CLK
//   slave   the key shifter itself
interface crypto1_key_shifter_if;
    logic        LOAD;
    logic [47:0] LOAD_STATE;
    logic        CLR;
    logic        KEY_CLK;
    logic        KEY_DATA;
    logic        KEY_VALID;
    logic        BUSY;
    logic        SENT;

    modport master (
        output LOAD,
        output LOAD_STATE,
        output CLR,
        output KEY_CLK,
        input  KEY_DATA,
        input  KEY_VALID,
        input  BUSY,
        input  SENT
    );

    modport slave (
        input  LOAD,
        input  LOAD_STATE,
        input  CLR,
        input  KEY_CLK,
        output KEY_DATA,
        output KEY_VALID,
        output BUSY,
        output SENT
    );
endinterface

// File: rtl/crypto1_key_shifter.sv
// crypto1_key_shifter
//
// Per-core key return path. Latches a matched 48-bit Crypto1 LFSR state,
// steps the LFSR backwards REWIND times to recover the original key, then
// shifts the key out MSB first, one bit per falling edge of KEY_CLK.
//
// Parameters:
//   REWIND   number of backward LFSR steps before transmission (0..63)
//
// Ports:
//   CLK      system clock, rising edge
//   RESETn   asynchronous active-low reset
//   bus      crypto1_key_shifter_if.slave
//              in : LOAD, LOAD_STATE, CLR, KEY_CLK
//              out: KEY_DATA, KEY_VALID, BUSY, SENT
module crypto1_key_shifter #(
    parameter int unsigned REWIND = 10
) (
    input  logic                   CLK,
    input  logic                   RESETn,
    crypto1_key_shifter_if.slave   bus
);

    typedef enum logic [1:0] {
        StIdle,
        StRewind,
        StSend,
        StDone
    } state_e;

    localparam bit         HasRewind  = (REWIND != 0);
    // Value of cnt_q on the last rewind step; unused when REWIND is 0.
    localparam logic [5:0] RewindLast = HasRewind ? 6'(REWIND - 1) : 6'd0;
    localparam logic [5:0] LastBit    = 6'd47;
    localparam logic [5:0] BitsTotal  = 6'd48;

    state_e      state_q;
    logic [47:0] shreg_q;
    logic [5:0]  cnt_q;
    logic        kc_q;
    logic        key_valid_q;
    logic        busy_q;
    logic        sent_q;
    logic        key_fall;

    // One backward Crypto1 LFSR step. The forward step is {fb, s[47:1]};
    // undoing it shifts the other way and recovers the old s[0] from the
    // feedback bit (now s[47]) and the remaining taps, each moved down by one.
    function automatic logic [47:0] rewind_step(input logic [47:0] s);
        logic b0;
        b0 = s[47] ^ s[4]  ^ s[8]  ^ s[9]  ^ s[11] ^ s[13] ^ s[14] ^ s[16] ^ s[18]
           ^ s[23] ^ s[24] ^ s[26] ^ s[28] ^ s[34] ^ s[38] ^ s[40] ^ s[41] ^ s[42];
        return {s[46:0], b0};
    endfunction

    // KEY_CLK is already CLK-synchronous; kc_q only provides edge history.
    assign key_fall = kc_q & ~bus.KEY_CLK;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q     <= StIdle;
            shreg_q     <= '0;
            cnt_q       <= '0;
            kc_q        <= 1'b0;
            key_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            sent_q      <= 1'b0;
        end else begin
            kc_q <= bus.KEY_CLK;
            if (bus.CLR) begin
                // Clearing shreg too keeps KEY_DATA low in idle.
                state_q     <= StIdle;
                shreg_q     <= '0;
                cnt_q       <= '0;
                key_valid_q <= 1'b0;
                busy_q      <= 1'b0;
                sent_q      <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (bus.LOAD) begin
                            shreg_q <= bus.LOAD_STATE;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                            if (HasRewind) begin
                                state_q <= StRewind;
                            end else begin
                                state_q     <= StSend;
                                key_valid_q <= 1'b1;
                            end
                        end
                    end

                    StRewind: begin
                        shreg_q <= rewind_step(shreg_q);
                        if (cnt_q == RewindLast) begin
                            cnt_q       <= '0;
                            state_q     <= StSend;
                            key_valid_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 6'd1;
                        end
                    end

                    StSend: begin
                        // Edges seen before entering SEND were registered while
                        // the state was still REWIND/IDLE and are not counted.
                        if (key_fall) begin
                            shreg_q <= {shreg_q[46:0], 1'b0};
                            if (cnt_q == LastBit) begin
                                cnt_q       <= BitsTotal;
                                state_q     <= StDone;
                                key_valid_q <= 1'b0;
                                busy_q      <= 1'b0;
                                sent_q      <= 1'b1;
                            end else begin
                                cnt_q <= cnt_q + 6'd1;
                            end
                        end
                    end

                    StDone: begin
                        // Hold until CLR or reset.
                    end
                endcase
            end
        end
    end

    assign bus.KEY_DATA  = shreg_q[47];
    assign bus.KEY_VALID = key_valid_q;
    assign bus.BUSY      = busy_q;
    assign bus.SENT      = sent_q;

    a_valid_in_send: assert property (@(posedge CLK) disable iff (!RESETn)
        key_valid_q == (state_q == StSend));
    a_busy_states: assert property (@(posedge CLK) disable iff (!RESETn)
        busy_q == (state_q == StRewind || state_q == StSend));
    a_sent_in_done: assert property (@(posedge CLK) disable iff (!RESETn)
        sent_q == (state_q == StDone));
    a_cnt_bound: assert property (@(posedge CLK) disable iff (!RESETn)
        cnt_q <= BitsTotal);

endmodule
